// File: rtl/snake_head_mover_if.sv
// Bundle of control inputs and head-state outputs exchanged between the
// snake head mover and the game logic that drives and consumes it.
interface snake_head_mover_if #(
   parameter int COORD_W = 10
);
   logic               start;
   logic               pause;
   logic [1:0]         dir_req;
   logic               dir_valid;
   logic [COORD_W-1:0] x_cell;
   logic [COORD_W-1:0] y_cell;
   logic [1:0]         dir;
   logic               step_pulse;
   logic               alive;
   logic               dead;

   // Game control side: issues start/pause/direction, observes the head.
   modport master (
      output start, pause, dir_req, dir_valid,
      input  x_cell, y_cell, dir, step_pulse, alive, dead
   );

   // Head mover side.
   modport slave (
      input  start, pause, dir_req, dir_valid,
      output x_cell, y_cell, dir, step_pulse, alive, dead
   );
endinterface

// File: rtl/snake_head_mover.sv
// Snake head mover: steps the head one grid cell per movement tick in the
// player-selected direction, with start/pause control, reversal rejection
// and either wall death or wrap-around at the playfield edges.
module snake_head_mover #(
   parameter int         GRID_W    = 40,
   parameter int         GRID_H    = 30,
   parameter int         COORD_W   = 10,
   parameter int         START_X   = 5,
   parameter int         START_Y   = 5,
   parameter logic [1:0] START_DIR = 2'b00,
   parameter int         TICK_DIV  = 5_000_000,
   parameter int         WRAP      = 0
) (
   input  logic              clk,
   input  logic              resetn,
   snake_head_mover_if.slave bus
);

   localparam int                 TICK_W     = $clog2(TICK_DIV);
   localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
   localparam int                 EXT_W      = COORD_W + 1;
   localparam logic [EXT_W-1:0]   GRID_W_EXT = EXT_W'(GRID_W);
   localparam logic [EXT_W-1:0]   GRID_H_EXT = EXT_W'(GRID_H);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_DEAD  = 2'b11
   } state_t;

   state_t             state_r;
   state_t             state_nxt_s;
   logic [COORD_W-1:0] x_r;
   logic [COORD_W-1:0] y_r;
   logic [1:0]         dir_r;
   logic [1:0]         pend_dir_r;
   logic [TICK_W-1:0]  tick_r;
   logic               step_pulse_r;
   logic               alive_r;
   logic               dead_r;

   logic               tick_hit_s;
   logic               restart_s;
   logic [EXT_W-1:0]   tx_s;
   logic [EXT_W-1:0]   ty_s;
   logic               off_s;
   logic [COORD_W-1:0] nx_s;
   logic [COORD_W-1:0] ny_s;
   logic               die_s;
   logic               move_s;
   logic [1:0]         ref_dir_s;
   logic               accept_s;
   logic               alive_nxt_s;
   logic               dead_nxt_s;
   logic               pulse_nxt_s;

   // A step is due only in RUN with no pause this cycle (pause wins over a step).
   assign tick_hit_s = (state_r == ST_RUN) && !bus.pause && (tick_r == TICK_LAST);
   assign restart_s  = (state_r == ST_DEAD) && bus.start;
   assign die_s      = tick_hit_s && off_s && (WRAP == 0);
   assign move_s     = tick_hit_s && !die_s;

   // In a step cycle the reversal check uses the direction being committed,
   // so a request there already applies to the following step.
   assign ref_dir_s  = tick_hit_s ? pend_dir_r : dir_r;
   assign accept_s   = bus.dir_valid && (state_r != ST_DEAD) &&
                       (bus.dir_req != (ref_dir_s ^ 2'b10));

   // Target cell one step ahead, computed one bit wider so x-1/y-1 at 0 is detectable.
   always_comb begin
      tx_s = {1'b0, x_r};
      ty_s = {1'b0, y_r};
      case (pend_dir_r)
         2'b00:   tx_s = {1'b0, x_r} + EXT_W'(1);
         2'b01:   ty_s = {1'b0, y_r} + EXT_W'(1);
         2'b10:   tx_s = {1'b0, x_r} - EXT_W'(1);
         2'b11:   ty_s = {1'b0, y_r} - EXT_W'(1);
         default: tx_s = {1'b0, x_r};
      endcase
      off_s = (tx_s >= GRID_W_EXT) || (ty_s >= GRID_H_EXT);
      if (tx_s[COORD_W]) begin
         nx_s = COORD_W'(GRID_W - 1);
      end else if (tx_s == GRID_W_EXT) begin
         nx_s = {COORD_W{1'b0}};
      end else begin
         nx_s = tx_s[COORD_W-1:0];
      end
      if (ty_s[COORD_W]) begin
         ny_s = COORD_W'(GRID_H - 1);
      end else if (ty_s == GRID_H_EXT) begin
         ny_s = {COORD_W{1'b0}};
      end else begin
         ny_s = ty_s[COORD_W-1:0];
      end
   end

   // Game state transitions.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.start) state_nxt_s = ST_RUN;
            else           state_nxt_s = ST_IDLE;
         end
         ST_RUN: begin
            if (bus.pause) state_nxt_s = ST_PAUSE;
            else if (die_s) state_nxt_s = ST_DEAD;
            else           state_nxt_s = ST_RUN;
         end
         ST_PAUSE: begin
            if (bus.pause) state_nxt_s = ST_PAUSE;
            else           state_nxt_s = ST_RUN;
         end
         ST_DEAD: begin
            if (bus.start) state_nxt_s = ST_RUN;
            else           state_nxt_s = ST_DEAD;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Status outputs decoded from the state being entered, registered below.
   always_comb begin
      alive_nxt_s = (state_nxt_s == ST_RUN) || (state_nxt_s == ST_PAUSE);
      dead_nxt_s  = (state_nxt_s == ST_DEAD);
      pulse_nxt_s = move_s;
   end

   // State register and registered status flags.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r      <= ST_IDLE;
         step_pulse_r <= 1'b0;
         alive_r      <= 1'b0;
         dead_r       <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         step_pulse_r <= pulse_nxt_s;
         alive_r      <= alive_nxt_s;
         dead_r       <= dead_nxt_s;
      end
   end

   // Head position, direction, pending request and movement tick counter.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         x_r        <= COORD_W'(START_X);
         y_r        <= COORD_W'(START_Y);
         dir_r      <= START_DIR;
         pend_dir_r <= START_DIR;
         tick_r     <= {TICK_W{1'b0}};
      end else if (restart_s) begin
         x_r        <= COORD_W'(START_X);
         y_r        <= COORD_W'(START_Y);
         dir_r      <= START_DIR;
         pend_dir_r <= START_DIR;
         tick_r     <= {TICK_W{1'b0}};
      end else begin
         if ((state_r == ST_RUN) && !bus.pause) begin
            tick_r <= tick_hit_s ? {TICK_W{1'b0}} : tick_r + TICK_W'(1);
         end
         if (move_s) begin
            x_r <= nx_s;
            y_r <= ny_s;
         end
         if (tick_hit_s) begin
            dir_r <= pend_dir_r;
         end
         if (accept_s) begin
            pend_dir_r <= bus.dir_req;
         end
      end
   end

   assign bus.x_cell     = x_r;
   assign bus.y_cell     = y_r;
   assign bus.dir        = dir_r;
   assign bus.step_pulse = step_pulse_r;
   assign bus.alive      = alive_r;
   assign bus.dead       = dead_r;

endmodule
